matmul_seq: RTL



---
 rtl/matmul_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/matmul_seq.sv
// Sequential signed N x N matrix multiplier (one MAC per clock, opcode 3'b010).
// Define MATMUL_SAT_EN to clamp out-of-range elements; otherwise they wrap to W bits.
module matmul_seq #(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int ACC_W = 2*W + $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [N*N*W-1:0]   a_in,
    input  logic [N*N*W-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [N*N*W-1:0]   result
);

    localparam int            CW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST      = CW'(N-1);
    localparam logic [2:0]    OP_MATMUL = 3'b010;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [N*N*W-1:0]        a_reg;
    logic [N*N*W-1:0]        b_reg;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           i;
    logic [CW-1:0]           j;
    logic [CW-1:0]           k;

    logic signed [W-1:0]     a_el;
    logic signed [W-1:0]     b_el;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_ovf;
    logic [W-1:0]            elem;
    logic                    last_k;
    logic                    last_elem;
    int                      a_idx;
    int                      b_idx;
    int                      p_idx;

    always_comb begin
        a_idx = (N*int'(i) + int'(k)) * W;
        b_idx = (N*int'(k) + int'(j)) * W;
        p_idx = (N*int'(i) + int'(j)) * W;
        a_el  = a_reg[a_idx +: W];
        b_el  = b_reg[b_idx +: W];
        prod  = a_el * b_el;
        prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        sum   = acc + prod_ext;
        last_k    = (k == LAST);
        last_elem = last_k && (i == LAST) && (j == LAST);
    end

    // The sum fits in W signed bits only if its top ACC_W-W+1 bits are all equal.
    always_comb begin
        sum_ovf = !((&sum[ACC_W-1:W-1]) || !(|sum[ACC_W-1:W-1]));
`ifdef MATMUL_SAT_EN
        if (sum_ovf) begin
            elem = sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            elem = sum[W-1:0];
        end
`else
        elem = sum[W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && (op == OP_MATMUL)) begin
                        a_reg  <= a_in;
                        b_reg  <= b_in;
                        acc    <= '0;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        ovf    <= 1'b0;
                        result <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!last_k) begin
                        acc <= sum;
                        k   <= k + CW'(1);
                    end else begin
                        result[p_idx +: W] <= elem;
                        if (sum_ovf) begin
                            ovf <= 1'b1;
                        end
                        acc <= '0;
                        k   <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            i <= (i == LAST) ? '0 : i + CW'(1);
                        end else begin
                            j <= j + CW'(1);
                        end
                        if (last_elem) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
